// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet receive parser and its payload realigner.
package eth_pkg;

  localparam int HEADER_BYTES = 14;
  localparam int MAC_W        = 48;
  localparam int ETYPE_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR1,
    ST_HDR2,
    ST_HDR3,
    ST_PAYLOAD,
    ST_FLUSH,
    ST_DROP
  } parser_state_t;

  typedef struct packed {
    logic [MAC_W-1:0]   dest;
    logic [MAC_W-1:0]   src;
    logic [ETYPE_W-1:0] etype;
  } eth_hdr_t;

  function automatic logic [2:0] keep_bytes(input logic [3:0] keep);
    keep_bytes = 3'(keep[0]) + 3'(keep[1]) + 3'(keep[2]) + 3'(keep[3]);
  endfunction

endpackage

// File: rtl/eth_realign_2b.sv
// Shifts the payload stream by two bytes: a 16-bit holding register carries the
// tail of each word into the next output beat, with a flush beat for the leftover.
module eth_realign_2b (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_load_h,
  input  logic        i_beat,
  input  logic        i_beat_last,
  input  logic        i_flush,
  input  logic [31:0] i_word,
  input  logic [3:0]  i_keep,
  input  logic        i_ready,
  output logic [31:0] o_data,
  output logic [3:0]  o_keep,
  output logic        o_valid,
  output logic        o_last
);

  logic [15:0] r_h;
  logic [1:0]  r_h_keep;
  logic [31:0] r_data;
  logic [3:0]  r_keep;
  logic        r_valid;
  logic        r_last;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_h      <= '0;
      r_h_keep <= '0;
      r_data   <= '0;
      r_keep   <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
    end else begin
      if (i_load_h || i_beat) begin
        r_h      <= i_word[15:0];
        r_h_keep <= i_keep[1:0];
      end
      // A new beat is only offered when the output slot is free or draining now.
      if (i_beat) begin
        r_data  <= {r_h, i_word[31:16]};
        r_keep  <= {r_h_keep, i_keep[3:2]};
        r_valid <= 1'b1;
        r_last  <= i_beat_last;
      end else if (i_flush) begin
        r_data  <= {r_h, 16'h0000};
        r_keep  <= {r_h_keep, 2'b00};
        r_valid <= 1'b1;
        r_last  <= 1'b1;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data  = r_data;
  assign o_keep  = r_keep;
  assign o_valid = r_valid;
  assign o_last  = r_last;

endmodule

// File: rtl/eth_frame_parser.sv
// Ethernet receive parser: captures MAC/EtherType header fields, realigns the payload
// onto 32-bit boundaries and reports frame length with runt/oversize status.
module eth_frame_parser
  import eth_pkg::*;
#(
  parameter int MIN_FRAME_BYTES = 60,
  parameter int MAX_FRAME_BYTES = 1514,
  parameter int CNT_W           = 16
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [31:0]        i_rx_data,
  input  logic               i_rxd_tvalid,
  input  logic [3:0]         i_rx_tkeep,
  input  logic               i_rx_tlast,
  output logic               o_rx_tready,
  output logic [MAC_W-1:0]   o_dest_mac,
  output logic [MAC_W-1:0]   o_src_mac,
  output logic [ETYPE_W-1:0] o_ether_type,
  output logic               o_hdr_valid,
  output logic [31:0]        o_payload_data,
  output logic [3:0]         o_payload_tkeep,
  output logic               o_payload_valid,
  output logic               o_payload_last,
  input  logic               i_payload_ready,
  output logic               o_frame_done,
  output logic [CNT_W-1:0]   o_frame_bytes,
  output logic               o_err_runt,
  output logic               o_err_oversize
);

  parser_state_t    r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [MAC_W-1:0] r_dest_stage, r_src_stage;
  eth_hdr_t         r_hdr_out;
  logic             r_hdr_valid;
  logic [CNT_W-1:0] r_fin_bytes;
  logic             r_err_runt, r_err_over;
  logic             r_final_pend;
  logic             r_frame_done;

  logic             w_pv, w_slot_free, w_tready, w_acc;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_cross, w_over;
  logic             w_load_h, w_beat, w_beat_last, w_beat_final, w_flush;
  logic             w_hdr_commit, w_done_direct, w_end;

  assign w_slot_free = !w_pv || i_payload_ready;

  // Header states wait for any pending beat so two done pulses can never coincide.
  always_comb begin
    w_tready = 1'b0;
    case (r_state)
      ST_FLUSH:            w_tready = 1'b0;
      ST_PAYLOAD, ST_DROP: w_tready = w_slot_free;
      default:             w_tready = !w_pv;
    endcase
    w_tready = w_tready && !i_rst;
  end

  assign o_rx_tready = w_tready;
  assign w_acc       = i_rxd_tvalid && w_tready;

  assign w_sum      = {1'b0, r_cnt} + {{(CNT_W-2){1'b0}}, keep_bytes(i_rx_tkeep)};
  assign w_cnt_next = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
  assign w_cross    = (r_state != ST_DROP) && (w_cnt_next > CNT_W'(MAX_FRAME_BYTES));
  assign w_over     = w_cross || (r_state == ST_DROP);

  always_comb begin
    w_state_next  = r_state;
    w_load_h      = 1'b0;
    w_beat        = 1'b0;
    w_beat_last   = 1'b0;
    w_beat_final  = 1'b0;
    w_flush       = 1'b0;
    w_hdr_commit  = 1'b0;
    w_done_direct = 1'b0;
    w_end         = 1'b0;
    case (r_state)
      ST_IDLE, ST_HDR1, ST_HDR2: begin
        if (w_acc) begin
          if (i_rx_tlast) begin
            w_end         = 1'b1;
            w_done_direct = 1'b1;
            w_state_next  = ST_IDLE;
          end else if (w_cross) begin
            w_state_next = ST_DROP;
          end else begin
            w_state_next = (r_state == ST_IDLE) ? ST_HDR1 :
                           (r_state == ST_HDR1) ? ST_HDR2 : ST_HDR3;
          end
        end
      end
      ST_HDR3: begin
        if (w_acc) begin
          w_load_h     = 1'b1;
          w_hdr_commit = (w_cnt_next >= CNT_W'(HEADER_BYTES));
          if (i_rx_tlast) begin
            w_end = 1'b1;
            if (i_rx_tkeep[1:0] != 2'b00) begin
              w_state_next = ST_FLUSH;
            end else begin
              w_done_direct = 1'b1;
              w_state_next  = ST_IDLE;
            end
          end else begin
            w_state_next = w_cross ? ST_DROP : ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (w_acc) begin
          w_beat = 1'b1;
          // Limit crossing truncates here; the beat carries exactly the legal bytes.
          if (w_cross) begin
            w_beat_last = 1'b1;
            if (i_rx_tlast) begin
              w_end        = 1'b1;
              w_beat_final = 1'b1;
              w_state_next = ST_IDLE;
            end else begin
              w_state_next = ST_DROP;
            end
          end else if (i_rx_tlast) begin
            w_end = 1'b1;
            if (i_rx_tkeep[1:0] == 2'b00) begin
              w_beat_last  = 1'b1;
              w_beat_final = 1'b1;
              w_state_next = ST_IDLE;
            end else begin
              w_state_next = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (w_slot_free) begin
          w_flush      = 1'b1;
          w_beat_final = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (w_acc && i_rx_tlast) begin
          w_end         = 1'b1;
          w_done_direct = 1'b1;
          w_state_next  = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_dest_stage <= '0;
      r_src_stage  <= '0;
      r_hdr_out    <= '0;
      r_hdr_valid  <= 1'b0;
      r_fin_bytes  <= '0;
      r_err_runt   <= 1'b0;
      r_err_over   <= 1'b0;
      r_final_pend <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_hdr_valid  <= w_hdr_commit;
      r_frame_done <= w_done_direct || (r_final_pend && w_pv && i_payload_ready);
      if (w_acc) begin
        r_cnt <= i_rx_tlast ? '0 : w_cnt_next;
        case (r_state)
          ST_IDLE: r_dest_stage[47:16] <= i_rx_data;
          ST_HDR1: begin
            r_dest_stage[15:0] <= i_rx_data[31:16];
            r_src_stage[47:32] <= i_rx_data[15:0];
          end
          ST_HDR2: r_src_stage[31:0] <= i_rx_data;
          default: ;
        endcase
      end
      if (w_hdr_commit)
        r_hdr_out <= '{dest: r_dest_stage, src: r_src_stage, etype: i_rx_data[31:16]};
      // Final status is latched at tlast and stays stable through the done pulse.
      if (w_end) begin
        r_fin_bytes <= w_over ? CNT_W'(MAX_FRAME_BYTES) : w_cnt_next;
        r_err_runt  <= !w_over && (w_cnt_next < CNT_W'(MIN_FRAME_BYTES));
        r_err_over  <= w_over;
      end
      if (w_beat || w_flush)
        r_final_pend <= w_beat_final;
      else if (w_pv && i_payload_ready)
        r_final_pend <= 1'b0;
    end
  end

  eth_realign_2b u_realign (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_load_h    (w_load_h),
    .i_beat      (w_beat),
    .i_beat_last (w_beat_last),
    .i_flush     (w_flush),
    .i_word      (i_rx_data),
    .i_keep      (i_rx_tkeep),
    .i_ready     (i_payload_ready),
    .o_data      (o_payload_data),
    .o_keep      (o_payload_tkeep),
    .o_valid     (w_pv),
    .o_last      (o_payload_last)
  );

  assign o_payload_valid = w_pv;
  assign o_dest_mac      = r_hdr_out.dest;
  assign o_src_mac       = r_hdr_out.src;
  assign o_ether_type    = r_hdr_out.etype;
  assign o_hdr_valid     = r_hdr_valid;
  assign o_frame_done    = r_frame_done;
  assign o_frame_bytes   = r_fin_bytes;
  assign o_err_runt      = r_err_runt;
  assign o_err_oversize  = r_err_over;

endmodule

// File: tb/tb_eth_frame_parser.sv
// Randomised scoreboard bench for eth_frame_parser: a byte-level frame model predicts
// header, payload beats and frame status; a monitor compares whatever the DUT emits.
module tb_eth_frame_parser;

  localparam int MINB  = 60;
  localparam int MAXB  = 1514;
  localparam int CNT_W = 16;

  typedef logic [7:0] bq_t[$];
  typedef struct { logic [31:0] data; logic [3:0] keep; logic last; } beat_t;
  typedef struct { logic [47:0] dest; logic [47:0] src; logic [15:0] et; } hdr_t;
  typedef struct { int bytes; logic runt; logic over; } done_t;

  logic             clk = 1'b0;
  logic             i_rst = 1'b0;
  logic [31:0]      i_rx_data = '0;
  logic             i_rxd_tvalid = 1'b0;
  logic [3:0]       i_rx_tkeep = '0;
  logic             i_rx_tlast = 1'b0;
  logic             i_payload_ready = 1'b1;
  logic             o_rx_tready;
  logic [47:0]      o_dest_mac, o_src_mac;
  logic [15:0]      o_ether_type;
  logic             o_hdr_valid;
  logic [31:0]      o_payload_data;
  logic [3:0]       o_payload_tkeep;
  logic             o_payload_valid, o_payload_last;
  logic             o_frame_done;
  logic [CNT_W-1:0] o_frame_bytes;
  logic             o_err_runt, o_err_oversize;

  beat_t exp_beats[$];
  hdr_t  exp_hdrs[$];
  done_t exp_dones[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    ready_mode = 0;
  bq_t   fb;

  always #5 clk = ~clk;

  eth_frame_parser #(.MIN_FRAME_BYTES(MINB), .MAX_FRAME_BYTES(MAXB), .CNT_W(CNT_W)) dut (
    .clk(clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rxd_tvalid(i_rxd_tvalid),
    .i_rx_tkeep(i_rx_tkeep), .i_rx_tlast(i_rx_tlast), .o_rx_tready(o_rx_tready),
    .o_dest_mac(o_dest_mac), .o_src_mac(o_src_mac), .o_ether_type(o_ether_type),
    .o_hdr_valid(o_hdr_valid), .o_payload_data(o_payload_data),
    .o_payload_tkeep(o_payload_tkeep), .o_payload_valid(o_payload_valid),
    .o_payload_last(o_payload_last), .i_payload_ready(i_payload_ready),
    .o_frame_done(o_frame_done), .o_frame_bytes(o_frame_bytes),
    .o_err_runt(o_err_runt), .o_err_oversize(o_err_oversize)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: works purely on the frame's byte list.
  task automatic push_expect(input bq_t q);
    int n, eff;
    beat_t b;
    hdr_t h;
    done_t d;
    n = q.size();
    eff = (n > MAXB) ? MAXB : n;
    if (n >= 14) begin
      for (int i = 0; i < 6; i++) begin
        h.dest[47-8*i -: 8] = q[i];
        h.src[47-8*i -: 8]  = q[6+i];
      end
      h.et = {q[12], q[13]};
      exp_hdrs.push_back(h);
    end
    for (int p = 14; p < eff; p += 4) begin
      b.data = '0;
      b.keep = '0;
      for (int j = 0; j < 4; j++) begin
        if (p + j < eff) begin
          b.data[31-8*j -: 8] = q[p+j];
          b.keep[3-j] = 1'b1;
        end
      end
      b.last = (p + 4 >= eff);
      exp_beats.push_back(b);
    end
    d.bytes = eff;
    d.runt  = (n < MINB);
    d.over  = (n > MAXB);
    exp_dones.push_back(d);
  endtask

  function automatic bq_t make_frame(input logic [47:0] d, input logic [47:0] s,
                                     input logic [15:0] et, input int n, input bit ramp);
    bq_t q;
    logic [111:0] h;
    h = {d, s, et};
    for (int i = 0; i < n; i++) begin
      if (i < 14) q.push_back(h[111-8*i -: 8]);
      else q.push_back(ramp ? 8'((i - 14) % 256) : 8'($urandom));
    end
    return q;
  endfunction

  task automatic wait_accept();
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (o_rx_tready) break;
      t++;
      if (t > 5000) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: tready still 0 after %0d cycles, expected 1", t);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mid_frame();
    #2 i_rst = 1'b1;
    #1;
    check("rst_tready", o_rx_tready, 0);
    check("rst_pvalid", o_payload_valid, 0);
    check("rst_dest", o_dest_mac, 0);
    check("rst_etype", o_ether_type, 0);
    check("rst_done", o_frame_done, 0);
    exp_beats.delete();
    exp_hdrs.delete();
    exp_dones.delete();
    i_rxd_tvalid = 1'b0;
    i_rx_tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    #1 check("rst_release_tready", o_rx_tready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bq_t q, input int gap_pct, input int abort_at);
    int n, nw;
    logic [31:0] w;
    logic [3:0] k;
    n = q.size();
    nw = (n + 3) / 4;
    push_expect(q);
    for (int wi = 0; wi < nw; wi++) begin
      if (wi == abort_at) begin
        reset_mid_frame();
        return;
      end
      while ($urandom_range(0, 99) < gap_pct) begin
        i_rxd_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      w = $urandom;
      k = '0;
      for (int j = 0; j < 4; j++) begin
        if (4 * wi + j < n) begin
          w[31-8*j -: 8] = q[4*wi+j];
          k[3-j] = 1'b1;
        end
      end
      i_rx_data = w;
      i_rx_tkeep = k;
      i_rx_tlast = (wi == nw - 1);
      i_rxd_tvalid = 1'b1;
      wait_accept();
    end
    i_rxd_tvalid = 1'b0;
    i_rx_tlast = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_beats.size() != 0 || exp_hdrs.size() != 0 || exp_dones.size() != 0) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 5000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d beats %0d dones still pending, expected 0",
               exp_beats.size(), exp_dones.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Downstream ready pattern: 0 = always ready, 1 = toggle, 2 = random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       i_payload_ready = 1'b1;
        1:       i_payload_ready = !i_payload_ready;
        default: i_payload_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  always @(negedge clk) begin : monitor
    beat_t b;
    hdr_t h;
    done_t d;
    logic [31:0] m;
    if (!i_rst) begin
      if (o_payload_valid && !i_payload_ready) check("tready_when_stalled", o_rx_tready, 0);
      if (o_payload_valid && i_payload_ready) begin
        if (exp_beats.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got data 0x%08h, expected no beat", o_payload_data);
        end else begin
          b = exp_beats.pop_front();
          for (int j = 0; j < 4; j++) m[31-8*j -: 8] = {8{b.keep[3-j]}};
          check("payload_data", o_payload_data & m, b.data);
          check("payload_keep", o_payload_tkeep, b.keep);
          check("payload_last", o_payload_last, b.last);
        end
      end
      if (o_hdr_valid) begin
        if (exp_hdrs.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_hdr: got hdr_valid 1, expected 0");
        end else begin
          h = exp_hdrs.pop_front();
          check("dest_mac", o_dest_mac, h.dest);
          check("src_mac", o_src_mac, h.src);
          check("ether_type", o_ether_type, h.et);
        end
      end
      if (o_frame_done) begin
        if (exp_dones.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got frame_done 1, expected 0");
        end else begin
          d = exp_dones.pop_front();
          $display("frame done: bytes=%0d runt=%0b oversize=%0b", o_frame_bytes, o_err_runt, o_err_oversize);
          check("frame_bytes", o_frame_bytes, d.bytes);
          check("err_runt", o_err_runt, d.runt);
          check("err_oversize", o_err_oversize, d.over);
        end
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [47:0] d1, s1;
    int len;
    d1 = 48'h001422012345;
    s1 = 48'h0014226789AB;
    #1 i_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tready", o_rx_tready, 0);
    check("reset_pvalid", o_payload_valid, 0);
    check("reset_hdr_valid", o_hdr_valid, 0);
    check("reset_src", o_src_mac, 0);
    check("reset_bytes", o_frame_bytes, 0);
    check("reset_errs", {o_err_runt, o_err_oversize, o_frame_done}, 0);
    i_rst = 1'b0;
    #1 check("tready_after_reset", o_rx_tready, 1);

    fb = make_frame(d1, s1, 16'h0800, 1514, 1'b1);
    send_frame(fb, 0, -1);
    drain();
    ready_mode = 1;
    send_frame(fb, 0, -1);
    drain();
    ready_mode = 0;

    fb = make_frame(d1, s1, 16'h86DD, 60, 1'b0);   send_frame(fb, 0, -1);
    fb = make_frame(s1, d1, 16'h0806, 59, 1'b0);   send_frame(fb, 0, -1);
    fb = make_frame(d1, s1, 16'h0800, 1520, 1'b1); send_frame(fb, 0, -1);
    fb = make_frame(d1, s1, 16'h0800, 8, 1'b0);    send_frame(fb, 0, -1);
    fb = make_frame(s1, d1, 16'h88F7, 100, 1'b0);  send_frame(fb, 0, -1);
    fb = make_frame(d1, s1, 16'h1234, 14, 1'b0);   send_frame(fb, 0, -1);
    fb = make_frame(d1, s1, 16'h1234, 13, 1'b0);   send_frame(fb, 0, -1);
    fb = make_frame(d1, s1, 16'h5678, 15, 1'b0);   send_frame(fb, 0, -1);
    fb = make_frame(d1, s1, 16'h0800, 1515, 1'b0); send_frame(fb, 0, -1);
    fb = make_frame(d1, s1, 16'h0800, 1516, 1'b0); send_frame(fb, 0, -1);
    drain();

    ready_mode = 2;
    for (int f = 0; f < 14; f++) begin
      if (f % 4 == 3) len = $urandom_range(1400, 1600);
      else len = $urandom_range(1, 130);
      fb = make_frame({$urandom, 16'($urandom)}, {$urandom, 16'($urandom)}, 16'($urandom), len, 1'b0);
      send_frame(fb, 20, -1);
    end
    drain();

    ready_mode = 0;
    fb = make_frame(d1, s1, 16'h0800, 1514, 1'b1);
    send_frame(fb, 0, 200);
    send_frame(fb, 0, -1);
    drain();

    check("beats_left", exp_beats.size(), 0);
    check("hdrs_left", exp_hdrs.size(), 0);
    check("dones_left", exp_dones.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
